spart_bus_intf: RTL and testbench
=================================

Name: spart_bus_intf

Overview:
- Processor-side bus interface and baud generator of the SPART. It sits directly downstream of the bus driver and decodes its iocs/iorw/ioaddr/databus cycles.
- Holds the 16-bit baud divisor buffer (DB low/high) and produces the 16x-oversample baud enable tick for the SPART TX and RX engines.
- Hands transmit bytes to the TX engine and returns RX data and status on the tri-state databus.

Parameters:
- DEFAULT_DIV, 16'd326: divisor loaded on reset. 50 MHz / (9600 × 16), rounded.
- STAT_PAD, 5: number of zero bits padding the status byte above bit 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- iocs  input  1  chip select, active high.
- iorw  input  1  1 = read (SPART drives databus), 0 = write.
- ioaddr  input  2  register select: 00 TX/RX buffer, 01 status, 10 DB low, 11 DB high.
- databus  inout  8  bidirectional data bus.
- rx_data  input  8  received byte from the RX engine.
- rda  input  1  receive data available, from the RX engine.
- tbr  input  1  transmit buffer ready, from the TX engine.
- tx_data  output  8  byte to transmit.
- tx_load  output  1  one-cycle pulse; TX engine captures tx_data.
- rx_ack  output  1  one-cycle pulse; RX engine clears rda.
- baud_en  output  1  16x-oversample enable tick.

Behaviour:
Reset (rst=1 at a rising edge):
- Divisor = DEFAULT_DIV; baud counter = DEFAULT_DIV-1.
- tx_data = 0; tx_load = 0; rx_ack = 0; baud_en = 0; overrun flag = 0.
- Databus is high-Z while rst=1.
- Reset mid-transaction discards the transaction. Pulses already scheduled for the next cycle are suppressed.

Write cycle (iocs=1, iorw=0, sampled at rising edge):
- 00:
  - If tbr=1: tx_data <= databus, and tx_load=1 for exactly the following cycle.
  - If tbr=0: write dropped, tx_data unchanged, no tx_load, overrun flag set (sticky).
- 01: ignored.
- 10: div[7:0] <= databus.
- 11: div[15:8] <= databus.
- Each cycle with iocs=1 is one transaction. A select held for N cycles performs N writes; for 00 that gives N tx_load pulses, each gated by tbr.

Read cycle (iocs=1, iorw=1):
- Databus is driven combinationally in the same cycle:
  - 00: rx_data.
  - 01: {STAT_PAD zeros, overrun, tbr, rda}.
  - 10: div[7:0].
  - 11: div[15:8].
- Side effects, taken at the rising edge:
  - 00: rx_ack=1 for the following cycle, regardless of rda.
  - 01: overrun cleared. If an overrun-setting event occurs in the same cycle, set wins.
- Databus is high-Z whenever iocs=0, iorw=0, or rst=1. Never drive during a write.

Baud generator:
- Down-counter cnt[15:0].
- Normal operation: baud_en = (cnt==0) && (div!=0), registered output. When cnt==0, cnt reloads div-1; otherwise it decrements.
- Resulting period: one pulse every div cycles. div=1 gives baud_en high every cycle.
- div=0: baud_en held 0 and cnt held 0. No pulses until a nonzero divisor is written.
- Divisor write: the cycle after any write to 10 or 11, cnt reloads with the new {div_hi, div_lo}-1. The first pulse after that write arrives after a full new period. No half-updated intermediate period is emitted between the low and high writes beyond this reload rule.
- Counter arithmetic is 16-bit unsigned with no wrap past 0.

Simultaneous events:
- Divisor write and cnt==0 in the same cycle: the pulse for that cycle is still emitted, and the reload uses the new divisor.

Test Plan:
- Reset behaviour: assert rst for 2 cycles, release with iocs=0 → databus=Z, tx_load=rx_ack=0, baud_en pulses every 326 cycles (first pulse 326 cycles after release).
- Divisor programming and readback:
  - Write 10←0x04, then 11←0x00.
  - Expect baud_en every 4 cycles, starting 4 cycles after the 11 write.
  - Read 10 → 0x04; read 11 → 0x00.
- Divisor special values: write div=0x0000 → no baud_en for 1000 cycles; then write div=0x0001 → baud_en high every cycle.
- Transmit handshake:
  - tbr=1, write 00←0xA5 → tx_data=0xA5, single-cycle tx_load the next cycle.
  - tbr=0, write 00←0x3C → no tx_load, tx_data stays 0xA5.
  - Status read → 0x04 (with rda=0, tbr=0).
  - Second status read → 0x00.
- Receive path: rda=1, rx_data=0x5A.
  - Read 01 → 0x03 with tbr=1.
  - Read 00 → databus=0x5A in the same cycle, rx_ack pulse for one cycle.
- Bus contention and reset abort:
  - Write cycles on all addresses → databus never driven by the DUT.
  - Assert rst in the same cycle as a 00 write with tbr=1 → no tx_load, tx_data=0.

Source files
------------

// File: rtl/spart_bus_intf.sv
// SPART processor bus interface: register decode, TX/RX handshake and the
// programmable 16x-oversample baud generator.
module spart_bus_intf #(
    parameter logic [15:0] DEFAULT_DIV = 16'd326,
    parameter int unsigned STAT_PAD    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  logic [7:0] databus,
    input  logic [7:0] rx_data,
    input  logic       rda,
    input  logic       tbr,
    output logic [7:0] tx_data,
    output logic       tx_load,
    output logic       rx_ack,
    output logic       baud_en
);

    logic [15:0] div;
    logic [15:0] cnt;
    logic [15:0] new_div;
    logic        overrun;
    logic [7:0]  rd_val;
    logic        wr;
    logic        rd;
    logic        wr_tx;
    logic        wr_div;
    logic        rd_rx;
    logic        rd_stat;

    assign wr      = iocs && !iorw;
    assign rd      = iocs && iorw;
    assign wr_tx   = wr && (ioaddr == 2'b00);
    assign wr_div  = wr && ioaddr[1];
    assign rd_rx   = rd && (ioaddr == 2'b00);
    assign rd_stat = rd && (ioaddr == 2'b01);

    always_comb begin
        rd_val = '0;
        case (ioaddr)
            2'b00: rd_val = rx_data;
            2'b01: rd_val = {{STAT_PAD{1'b0}}, overrun, tbr, rda};
            2'b10: rd_val = div[7:0];
            2'b11: rd_val = div[15:8];
            default: rd_val = '0;
        endcase
    end

    assign databus = (rd && !rst) ? rd_val : 'z;

    // Divisor as it will be after this edge; the counter reload uses it directly
    // so the first pulse after a divisor write comes a full new period later.
    always_comb begin
        new_div = div;
        if (wr_div) begin
            if (ioaddr[0])
                new_div = {databus, div[7:0]};
            else
                new_div = {div[15:8], databus};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= DEFAULT_DIV;
            cnt     <= DEFAULT_DIV - 16'd1;
            baud_en <= 1'b0;
            tx_data <= '0;
            tx_load <= 1'b0;
            rx_ack  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            div     <= new_div;
            baud_en <= (cnt == '0) && (div != '0);

            if (wr_div)
                cnt <= (new_div == '0) ? '0 : new_div - 16'd1;
            else if (div == '0)
                cnt <= '0;
            else if (cnt == '0)
                cnt <= div - 16'd1;
            else
                cnt <= cnt - 16'd1;

            tx_load <= wr_tx && tbr;
            if (wr_tx && tbr)
                tx_data <= databus;

            rx_ack <= rd_rx;

            // A dropped write and a status read in the same cycle keep the flag set.
            if (wr_tx && !tbr)
                overrun <= 1'b1;
            else if (rd_stat)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spart_bus_intf.sv
// Directed self-checking bench for spart_bus_intf: vector table for the bus
// handshake plus hand-written sequences for baud timing and reset abort.
module tb_spart_bus_intf;

    logic       clk = 1'b0;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] rx_data;
    logic       rda;
    logic       tbr;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       rx_ack;
    logic       baud_en;

    logic       tb_drv;
    logic [7:0] tb_val;

    int n_checks = 0;
    int n_fail   = 0;

    // The bench drives a known pattern whenever the DUT must not drive, so any
    // DUT drive shows up as a corrupted value on the bus.
    assign databus = tb_drv ? tb_val : 'z;

    always #5 clk = ~clk;

    spart_bus_intf #(.DEFAULT_DIV(16'd326), .STAT_PAD(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rx_data (rx_data),
        .rda     (rda),
        .tbr     (tbr),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .rx_ack  (rx_ack),
        .baud_en (baud_en)
    );

    typedef struct {
        logic       iocs;
        logic       iorw;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       tbr;
        logic       rda;
        logic [7:0] rxd;
        logic [7:0] exp_bus;
        logic       exp_load;
        logic       exp_ack;
        logic [7:0] exp_txd;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts rising edges until baud_en is seen; returns 0 if none within limit.
    task automatic wait_baud(input int limit, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (n < limit && !found) begin
            @(posedge clk);
            #1;
            n++;
            if (baud_en) found = 1'b1;
        end
        if (!found) n = 0;
    endtask

    task automatic count_baud(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (baud_en) pulses++;
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = addr;
        tb_drv = 1'b1;
        tb_val = data;
        @(posedge clk);
        #1;
        iocs   = 1'b0;
        tb_val = 8'h96;
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [7:0] exp, input string name);
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = addr;
        tb_drv = 1'b0;
        #1;
        check(name, {8'h00, databus}, {8'h00, exp});
        @(posedge clk);
        #1;
        iocs   = 1'b0;
        tb_drv = 1'b1;
        tb_val = 8'h96;
    endtask

    initial begin
        int n;
        //            cs  rw  ad     wd     tbr rda rxd    bus    ld  ack txd
        vecs[0]  = '{1'b0,1'b0,2'd0,8'h00,1'b1,1'b0,8'h00,8'h96,1'b0,1'b0,8'h00};
        vecs[1]  = '{1'b1,1'b0,2'd0,8'hA5,1'b1,1'b0,8'h00,8'hA5,1'b1,1'b0,8'hA5};
        vecs[2]  = '{1'b0,1'b0,2'd0,8'h00,1'b0,1'b0,8'h00,8'h96,1'b0,1'b0,8'hA5};
        vecs[3]  = '{1'b1,1'b0,2'd0,8'h3C,1'b0,1'b0,8'h00,8'h3C,1'b0,1'b0,8'hA5};
        vecs[4]  = '{1'b1,1'b1,2'd1,8'h00,1'b0,1'b0,8'h00,8'h04,1'b0,1'b0,8'hA5};
        vecs[5]  = '{1'b1,1'b1,2'd1,8'h00,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'hA5};
        vecs[6]  = '{1'b1,1'b1,2'd1,8'h00,1'b1,1'b1,8'h5A,8'h03,1'b0,1'b0,8'hA5};
        vecs[7]  = '{1'b1,1'b1,2'd0,8'h00,1'b1,1'b1,8'h5A,8'h5A,1'b0,1'b1,8'hA5};
        vecs[8]  = '{1'b0,1'b0,2'd0,8'h00,1'b1,1'b1,8'h5A,8'h96,1'b0,1'b0,8'hA5};
        vecs[9]  = '{1'b1,1'b1,2'd0,8'h00,1'b1,1'b0,8'hC3,8'hC3,1'b0,1'b1,8'hA5};
        vecs[10] = '{1'b1,1'b0,2'd1,8'h55,1'b1,1'b0,8'h00,8'h55,1'b0,1'b0,8'hA5};
        vecs[11] = '{1'b1,1'b0,2'd0,8'h11,1'b1,1'b0,8'h00,8'h11,1'b1,1'b0,8'h11};
        vecs[12] = '{1'b1,1'b0,2'd0,8'h22,1'b1,1'b0,8'h00,8'h22,1'b1,1'b0,8'h22};
        vecs[13] = '{1'b1,1'b0,2'd0,8'h33,1'b0,1'b0,8'h00,8'h33,1'b0,1'b0,8'h22};
        vecs[14] = '{1'b1,1'b1,2'd1,8'h00,1'b0,1'b0,8'h00,8'h04,1'b0,1'b0,8'h22};
        vecs[15] = '{1'b1,1'b1,2'd2,8'h00,1'b0,1'b0,8'h00,8'h46,1'b0,1'b0,8'h22};
        vecs[16] = '{1'b1,1'b1,2'd3,8'h00,1'b0,1'b0,8'h00,8'h01,1'b0,1'b0,8'h22};
        vecs[17] = '{1'b0,1'b0,2'd0,8'h00,1'b0,1'b0,8'h00,8'h96,1'b0,1'b0,8'h22};

        // Reset held for two edges with a read selected: bus must stay undriven.
        rst     = 1'b1;
        iocs    = 1'b1;
        iorw    = 1'b1;
        ioaddr  = 2'd0;
        rx_data = 8'h5A;
        rda     = 1'b0;
        tbr     = 1'b1;
        tb_drv  = 1'b1;
        tb_val  = 8'h96;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_hiz", {8'h00, databus}, 16'h0096);
        check("rst_tx_load", {15'd0, tx_load}, 16'd0);
        check("rst_rx_ack", {15'd0, rx_ack}, 16'd0);
        check("rst_baud_en", {15'd0, baud_en}, 16'd0);
        check("rst_tx_data", {8'h00, tx_data}, 16'h0000);
        rst     = 1'b0;
        iocs    = 1'b0;
        iorw    = 1'b0;
        rx_data = 8'h00;

        wait_baud(2000, n);
        check("baud_first_default", n[15:0], 16'd326);
        wait_baud(2000, n);
        check("baud_period_default", n[15:0], 16'd326);

        for (int i = 0; i < 18; i++) begin
            iocs    = vecs[i].iocs;
            iorw    = vecs[i].iorw;
            ioaddr  = vecs[i].addr;
            tbr     = vecs[i].tbr;
            rda     = vecs[i].rda;
            rx_data = vecs[i].rxd;
            tb_drv  = !(vecs[i].iocs && vecs[i].iorw);
            tb_val  = vecs[i].iocs ? vecs[i].wdata : 8'h96;
            #1;
            check($sformatf("vec%0d_bus", i), {8'h00, databus}, {8'h00, vecs[i].exp_bus});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_tx_load", i), {15'd0, tx_load}, {15'd0, vecs[i].exp_load});
            check($sformatf("vec%0d_rx_ack", i), {15'd0, rx_ack}, {15'd0, vecs[i].exp_ack});
            check($sformatf("vec%0d_tx_data", i), {8'h00, tx_data}, {8'h00, vecs[i].exp_txd});
        end
        iocs   = 1'b0;
        iorw   = 1'b0;
        tb_drv = 1'b1;
        tb_val = 8'h96;
        rda    = 1'b0;
        tbr    = 1'b0;

        // Divisor = 4, readback, then new divisor landing on a terminal count.
        bus_write(2'd2, 8'h04);
        bus_write(2'd3, 8'h00);
        wait_baud(50, n);
        check("baud_first_div4", n[15:0], 16'd4);
        wait_baud(50, n);
        check("baud_period_div4", n[15:0], 16'd4);
        bus_read(2'd2, 8'h04, "read_div_lo");
        bus_read(2'd3, 8'h00, "read_div_hi");
        wait_baud(50, n);
        repeat (3) @(posedge clk);
        #1;
        bus_write(2'd2, 8'h06);
        check("baud_on_div_write", {15'd0, baud_en}, 16'd1);
        wait_baud(50, n);
        check("baud_after_div_write", n[15:0], 16'd6);

        bus_write(2'd2, 8'h00);
        bus_write(2'd3, 8'h00);
        count_baud(1000, n);
        check("baud_div0_silent", n[15:0], 16'd0);
        bus_write(2'd2, 8'h01);
        count_baud(10, n);
        check("baud_div1_every_cycle", n[15:0], 16'd10);

        // Set overrun, then reset coinciding with an accepted TX write.
        tbr = 1'b0;
        bus_write(2'd0, 8'h44);
        tbr    = 1'b1;
        rst    = 1'b1;
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = 2'd0;
        tb_val = 8'h77;
        @(posedge clk);
        #1;
        check("abort_tx_load", {15'd0, tx_load}, 16'd0);
        check("abort_tx_data", {8'h00, tx_data}, 16'h0000);
        rst    = 1'b0;
        iocs   = 1'b0;
        tb_val = 8'h96;
        tbr    = 1'b0;
        bus_read(2'd1, 8'h00, "status_after_reset");
        wait_baud(2000, n);
        check("baud_after_reset", n[15:0], 16'd325);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
